// File: rtl/load_ext_pipe.sv
// load_ext_pipe: load-data byte/half/word/dword extraction with sign/zero extension,
// registered output stage plus one-entry skid buffer. Rev 1.0
`default_nettype none

module load_ext_pipe #(
   parameter  int DATA_W = 32,
   parameter  int TAG_W  = 5,
   localparam int OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_rdata,
   input  logic [OFF_W-1:0]  in_off,
   input  logic [1:0]        in_size,
   input  logic              in_signed,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err
);

   localparam logic [DATA_W-1:0] c_ones    = '1;
   localparam logic [7:0]        c_data_w  = 8'(DATA_W);
   localparam logic [OFF_W-1:0]  c_off_one = '1;

   logic [7:0]        w_fw;
   logic [DATA_W-1:0] w_shift;
   logic [DATA_W-1:0] w_mask;
   logic [DATA_W-1:0] w_top;
   logic              w_msb;
   logic              w_misalign;
   logic              w_illegal;
   logic              w_err;
   logic [DATA_W-1:0] w_data;

   // Shifting past the vector width yields zero, so a full-width field gets an all-ones mask.
   always_comb begin
      w_fw       = 8'd8 << in_size;
      w_illegal  = (w_fw > c_data_w);
      w_misalign = |(in_off & ~(c_off_one << in_size));
      w_err      = w_illegal | w_misalign;
      w_shift    = in_rdata >> {in_off, 3'b000};
      w_mask     = ~(c_ones << w_fw);
      w_top      = w_mask & ~(w_mask >> 1);
      w_msb      = |(w_shift & w_top);
      w_data     = (w_shift & w_mask) | ({DATA_W{in_signed & w_msb}} & ~w_mask);
      if (w_err) begin
         w_data = '0;
      end
   end

   logic              or_valid_q, or_valid_d;
   logic [DATA_W-1:0] or_data_q,  or_data_d;
   logic [TAG_W-1:0]  or_tag_q,   or_tag_d;
   logic              or_err_q,   or_err_d;
   logic              sk_valid_q, sk_valid_d;
   logic [DATA_W-1:0] sk_data_q,  sk_data_d;
   logic [TAG_W-1:0]  sk_tag_q,   sk_tag_d;
   logic              sk_err_q,   sk_err_d;
   logic              in_ready_q;
   logic              w_push;
   logic              w_pop;

   assign w_push = in_valid & in_ready_q;
   assign w_pop  = or_valid_q & out_ready;

   always_comb begin
      or_valid_d = or_valid_q;
      or_data_d  = or_data_q;
      or_tag_d   = or_tag_q;
      or_err_d   = or_err_q;
      sk_valid_d = sk_valid_q;
      sk_data_d  = sk_data_q;
      sk_tag_d   = sk_tag_q;
      sk_err_d   = sk_err_q;
      if (!or_valid_q || w_pop) begin
         if (sk_valid_q) begin
            or_valid_d = 1'b1;
            or_data_d  = sk_data_q;
            or_tag_d   = sk_tag_q;
            or_err_d   = sk_err_q;
            sk_valid_d = w_push;
            if (w_push) begin
               sk_data_d = w_data;
               sk_tag_d  = in_tag;
               sk_err_d  = w_err;
            end
         end else if (w_push) begin
            or_valid_d = 1'b1;
            or_data_d  = w_data;
            or_tag_d   = in_tag;
            or_err_d   = w_err;
         end else begin
            or_valid_d = 1'b0;
         end
      end else if (w_push) begin
         sk_valid_d = 1'b1;
         sk_data_d  = w_data;
         sk_tag_d   = in_tag;
         sk_err_d   = w_err;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         or_valid_q <= 1'b0;
         or_data_q  <= '0;
         or_tag_q   <= '0;
         or_err_q   <= 1'b0;
         sk_valid_q <= 1'b0;
         sk_data_q  <= '0;
         sk_tag_q   <= '0;
         sk_err_q   <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         or_valid_q <= or_valid_d;
         or_data_q  <= or_data_d;
         or_tag_q   <= or_tag_d;
         or_err_q   <= or_err_d;
         sk_valid_q <= sk_valid_d;
         sk_data_q  <= sk_data_d;
         sk_tag_q   <= sk_tag_d;
         sk_err_q   <= sk_err_d;
         in_ready_q <= !sk_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = or_valid_q;
   assign out_data  = or_data_q;
   assign out_tag   = or_tag_q;
   assign out_err   = or_err_q;

endmodule

`default_nettype wire
